mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between the instruction-fetch (IF) requester and the data-memory (ME) requester.
- Sequences each transfer as grant -> memory handshake -> response.
- Produces the busy stalls that the hazard unit consumes: oStall_IF feeds iStall_IF, and oStall_ME feeds iStall_ME.
- Sits between the IF/ME stages and the external memory interface.

---
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch (IF) and data memory (ME).
// Define MEM_ARB_TIMEOUT_EN to add a bus watchdog that forces completion and sets a sticky oErr.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ME_STREAK_MAX = 4,
  parameter int unsigned TIMEOUT_CYC   = 64
) (
  input  logic                iClk,
  input  logic                nRst,
  input  logic                iIF_req,
  input  logic [ADDR_W-1:0]   iIF_addr,
  input  logic                iAbort_IF,
  output logic [DATA_W-1:0]   oIF_rdata,
  output logic                oIF_ack,
  input  logic                iME_req,
  input  logic                iME_we,
  input  logic [DATA_W/8-1:0] iME_be,
  input  logic [ADDR_W-1:0]   iME_addr,
  input  logic [DATA_W-1:0]   iME_wdata,
  output logic [DATA_W-1:0]   oME_rdata,
  output logic                oME_ack,
  output logic                oMem_req,
  output logic                oMem_we,
  output logic [DATA_W/8-1:0] oMem_be,
  output logic [ADDR_W-1:0]   oMem_addr,
  output logic [DATA_W-1:0]   oMem_wdata,
  input  logic                iMem_ack,
  input  logic [DATA_W-1:0]   iMem_rdata,
  output logic                oStall_IF,
  output logic                oStall_ME,
  output logic                oErr
);

  localparam int unsigned STREAK_W = 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUS_IF = 2'd1;
  localparam logic [1:0] BUS_ME = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [STREAK_W-1:0] streak;
  logic                abort_q;
  logic                if_ok;
  logic                grant_if;
  logic                grant_me;
  logic                mem_done;
  logic                timeout;
  logic [DATA_W-1:0]   mem_data;

  if ((ME_STREAK_MAX < 1) || (ME_STREAK_MAX > 15) || (TIMEOUT_CYC < 1)) begin : g_param_check
    $error("mem_port_arbiter: ME_STREAK_MAX must be 1..15 and TIMEOUT_CYC >= 1");
  end

  always_ff @(posedge iClk or posedge nRst) begin
    if (nRst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Arbitration and transfer sequencing; a timed-out transfer completes with zero data.
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_me  = 1'b0;
    mem_done  = 1'b0;
    if_ok     = iIF_req & ~iAbort_IF;
    mem_data  = iMem_ack ? iMem_rdata : '0;
    case (state)
      IDLE: begin
        if (iME_req && !(if_ok && (streak == STREAK_W'(ME_STREAK_MAX)))) begin
          grant_me  = 1'b1;
          state_nxt = BUS_ME;
        end else if (if_ok) begin
          grant_if  = 1'b1;
          state_nxt = BUS_IF;
        end
      end
      BUS_IF, BUS_ME: begin
        if (iMem_ack || timeout) begin
          mem_done  = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge nRst) begin
    if (nRst) begin
      oMem_req   <= 1'b0;
      oMem_we    <= 1'b0;
      oMem_be    <= '0;
      oMem_addr  <= '0;
      oMem_wdata <= '0;
      oIF_ack    <= 1'b0;
      oIF_rdata  <= '0;
      oME_ack    <= 1'b0;
      oME_rdata  <= '0;
    end else begin
      oIF_ack <= 1'b0;
      oME_ack <= 1'b0;
      if (grant_me) begin
        oMem_req   <= 1'b1;
        oMem_we    <= iME_we;
        oMem_be    <= iME_be;
        oMem_addr  <= iME_addr;
        oMem_wdata <= iME_wdata;
      end else if (grant_if) begin
        oMem_req   <= 1'b1;
        oMem_we    <= 1'b0;
        oMem_be    <= '1;
        oMem_addr  <= iIF_addr;
        oMem_wdata <= '0;
      end
      // A flushed fetch still finishes on the bus but never reaches the fetch stage.
      if (mem_done) begin
        oMem_req <= 1'b0;
        if (state == BUS_ME) begin
          oME_ack   <= 1'b1;
          oME_rdata <= mem_data;
        end else if (!(abort_q || iAbort_IF)) begin
          oIF_ack   <= 1'b1;
          oIF_rdata <= mem_data;
        end
      end
    end
  end

  // Fairness: bound how long a waiting fetch can be starved by data accesses.
  always_ff @(posedge iClk or posedge nRst) begin
    if (nRst) begin
      streak  <= '0;
      abort_q <= 1'b0;
    end else begin
      if (grant_if || !iIF_req)
        streak <= '0;
      else if (grant_me && (streak != STREAK_W'(ME_STREAK_MAX)))
        streak <= streak + STREAK_W'(1);
      if ((state == BUS_IF) && iAbort_IF)
        abort_q <= 1'b1;
      else if (state == RESP)
        abort_q <= 1'b0;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  assign timeout = (tmo_cnt == TMO_W'(TIMEOUT_CYC)) & ~iMem_ack;

  always_ff @(posedge iClk or posedge nRst) begin
    if (nRst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if ((state == BUS_IF) || (state == BUS_ME)) tmo_cnt <= tmo_cnt + TMO_W'(1);
      else                                        tmo_cnt <= '0;
      if (timeout && ((state == BUS_IF) || (state == BUS_ME))) err_q <= 1'b1;
    end
  end

  assign oErr = err_q;
`else
  assign timeout = 1'b0;
  assign oErr    = 1'b0;
`endif

  assign oStall_IF = iIF_req & ~oIF_ack;
  assign oStall_ME = iME_req & ~oME_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic checked against a
// transaction-level model of the arbiter (default build, watchdog disabled).
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned BW   = DW / 8;
  localparam int unsigned SMAX = 4;

  localparam bit [4:0] T1_ACK   = 5'b01000;
  localparam bit [4:0] T1_STALL = 5'b00111;
  localparam bit [4:0] T1_MREQ  = 5'b00110;
  localparam bit [8:0] T4_MREQ  = 9'b000111110;
  localparam bit [1:0] G2       = 2'b01;
  localparam bit [5:0] G3       = 6'b101111;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_abort, if_ack;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          me_req, me_we, me_ack;
  logic [BW-1:0] me_be;
  logic [AW-1:0] me_addr;
  logic [DW-1:0] me_wdata, me_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata_in;
  logic          stall_if, stall_me, err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .ME_STREAK_MAX(SMAX), .TIMEOUT_CYC(64)
  ) dut (
    .iClk(clk), .nRst(rst),
    .iIF_req(if_req), .iIF_addr(if_addr), .iAbort_IF(if_abort),
    .oIF_rdata(if_rdata), .oIF_ack(if_ack),
    .iME_req(me_req), .iME_we(me_we), .iME_be(me_be), .iME_addr(me_addr),
    .iME_wdata(me_wdata), .oME_rdata(me_rdata), .oME_ack(me_ack),
    .oMem_req(mem_req), .oMem_we(mem_we), .oMem_be(mem_be), .oMem_addr(mem_addr),
    .oMem_wdata(mem_wdata), .iMem_ack(mem_ack), .iMem_rdata(mem_rdata_in),
    .oStall_IF(stall_if), .oStall_ME(stall_me), .oErr(err)
  );

  int vectors = 0;
  int miscompares = 0;

  // Transaction-level model: one transfer owns the port from grant until its response cycle.
  bit            m_busy, m_is_if, m_done, m_killed;
  int unsigned   m_streak;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [BW-1:0] m_be;
  logic [DW-1:0] m_wdata;
  logic          e_if_ack, e_me_ack;
  logic [DW-1:0] e_if_rdata, e_me_rdata;
  logic          last_if_ack, last_me_ack;

  logic          p_if, p_ab, p_me, p_we, p_mack;
  logic [AW-1:0] p_if_addr, p_me_addr;
  logic [BW-1:0] p_be;
  logic [DW-1:0] p_wdata, p_rdata;

  int            mem_cnt, mem_lat, force_lat;
  logic [DW-1:0] fixed_data;
  logic          prev_mem_req;
  bit            grants[$];
  int            if_left, me_left;
  logic [AW-1:0] s_if_addr, s_me_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_is_if = 0; m_done = 0; m_killed = 0; m_streak = 0;
    m_addr = '0; m_we = 1'b0; m_be = '0; m_wdata = '0;
    e_if_ack = 1'b0; e_me_ack = 1'b0; e_if_rdata = '0; e_me_rdata = '0;
    last_if_ack = 1'b0; last_me_ack = 1'b0;
    mem_cnt = 0; prev_mem_req = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present before the edge.
  task automatic model_edge();
    bit if_ok;
    e_if_ack = 1'b0;
    e_me_ack = 1'b0;
    if (!m_busy) begin
      if_ok = p_if && !p_ab;
      if (p_me && !(if_ok && m_streak == SMAX)) begin
        m_busy = 1; m_is_if = 0; m_done = 0; m_killed = 0;
        m_addr = p_me_addr; m_we = p_we; m_be = p_be; m_wdata = p_wdata;
        m_streak = p_if ? ((m_streak < SMAX) ? m_streak + 1 : SMAX) : 0;
      end else if (if_ok) begin
        m_busy = 1; m_is_if = 1; m_done = 0; m_killed = 0;
        m_addr = p_if_addr; m_we = 1'b0; m_be = '1; m_wdata = '0;
        m_streak = 0;
      end else if (!p_if) begin
        m_streak = 0;
      end
    end else begin
      if (!p_if) m_streak = 0;
      if (!m_done) begin
        if (m_is_if && p_ab) m_killed = 1;
        if (p_mack) begin
          m_done = 1;
          if (!m_is_if) begin
            e_me_ack = 1'b1; e_me_rdata = p_rdata;
          end else if (!m_killed) begin
            e_if_ack = 1'b1; e_if_rdata = p_rdata;
          end
        end
      end else begin
        m_busy = 0;
      end
    end
  endtask

  // Memory responder: acks mem_lat cycles after the request is first seen.
  task automatic mem_drive();
    if (m_busy && !m_done) begin
      mem_cnt++;
      if (mem_cnt == 1) mem_lat = (force_lat != 0) ? force_lat : int'($urandom_range(1, 4));
      mem_ack      = (mem_cnt == mem_lat + 1);
      mem_rdata_in = (force_lat != 0) ? fixed_data : $urandom;
    end else begin
      mem_cnt      = 0;
      mem_ack      = 1'b0;
      mem_rdata_in = $urandom;
    end
  endtask

  task automatic sample();
    bit exp_req;
    mem_drive();
    @(negedge clk);
    exp_req = m_busy && !m_done;
    check("mem_req", 64'(mem_req), 64'(exp_req));
    if (exp_req) begin
      check("mem_addr", 64'(mem_addr), 64'(m_addr));
      check("mem_we", 64'(mem_we), 64'(m_we));
      check("mem_be", 64'(mem_be), 64'(m_be));
      check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    end
    check("if_ack", 64'(if_ack), 64'(e_if_ack));
    check("me_ack", 64'(me_ack), 64'(e_me_ack));
    check("if_rdata", 64'(if_rdata), 64'(e_if_rdata));
    check("me_rdata", 64'(me_rdata), 64'(e_me_rdata));
    check("stall_if", 64'(stall_if), 64'(if_req & ~e_if_ack));
    check("stall_me", 64'(stall_me), 64'(me_req & ~e_me_ack));
    check("err", 64'(err), 64'(1'b0));
    if (mem_req && !prev_mem_req) grants.push_back(mem_addr >= 32'h1000);
    prev_mem_req = mem_req;
    p_if = if_req; p_ab = if_abort; p_me = me_req; p_we = me_we; p_mack = mem_ack;
    p_if_addr = if_addr; p_me_addr = me_addr; p_be = me_be; p_wdata = me_wdata;
    p_rdata = mem_rdata_in;
  endtask

  task automatic step();
    @(posedge clk);
    last_if_ack = e_if_ack;
    last_me_ack = e_me_ack;
    model_edge();
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_mem_req", 64'(mem_req), 64'(1'b0));
    check("rst_me_ack", 64'(me_ack), 64'(1'b0));
    check("rst_if_ack", 64'(if_ack), 64'(1'b0));
    if_req = 1'b0; if_abort = 1'b0; me_req = 1'b0; mem_ack = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drive_scripted();
    if (last_if_ack && if_left > 0) begin if_left--; s_if_addr += 4; end
    if (last_me_ack && me_left > 0) begin me_left--; s_me_addr += 4; end
    if_req = (if_left > 0); if_addr = s_if_addr; if_abort = 1'b0;
    me_req = (me_left > 0); me_addr = s_me_addr;
  endtask

  task automatic new_me_payload();
    me_we    = 1'($urandom_range(0, 1));
    me_be    = BW'($urandom_range(1, (1 << BW) - 1));
    me_addr  = $urandom & ~32'h3;
    me_wdata = $urandom;
  endtask

  task automatic drive_random();
    bit was_abort;
    was_abort = if_abort;
    if_abort  = 1'b0;
    if (last_if_ack || was_abort) begin
      if_req  = 1'($urandom_range(0, 1));
      if_addr = $urandom & ~32'h3;
    end else if (!if_req) begin
      if ($urandom_range(0, 2) == 0) begin if_req = 1'b1; if_addr = $urandom & ~32'h3; end
    end else if (!e_if_ack && $urandom_range(0, 15) == 0) begin
      if_abort = 1'b1;
    end
    if (last_me_ack) begin
      me_req = 1'($urandom_range(0, 1));
      new_me_payload();
    end else if (!me_req && $urandom_range(0, 2) == 0) begin
      me_req = 1'b1;
      new_me_payload();
    end
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_abort = 1'b0; if_addr = '0;
    me_req = 1'b0; me_we = 1'b0; me_be = '0; me_addr = '0; me_wdata = '0;
    mem_ack = 1'b0; mem_rdata_in = '0;
    force_lat = 1; fixed_data = 32'h0000_0013; mem_lat = 1;
    if_left = 0; me_left = 0; s_if_addr = '0; s_me_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_mem_req", 64'(mem_req), 64'(1'b0));
    check("reset_mem_addr", 64'(mem_addr), 64'(32'h0));
    check("reset_if_ack", 64'(if_ack), 64'(1'b0));
    check("reset_me_ack", 64'(me_ack), 64'(1'b0));
    check("reset_rdata", 64'({if_rdata, me_rdata}), 64'(0));
    check("reset_err", 64'(err), 64'(1'b0));
    @(posedge clk);
    #1 rst = 1'b0;

    // Single fetch, 1-cycle memory
    if_left = 1; s_if_addr = 32'h0000_0100;
    for (int c = 0; c < 5; c++) begin
      drive_scripted();
      sample();
      check("t1_ack", 64'(if_ack), 64'(T1_ACK[c]));
      check("t1_stall", 64'(stall_if), 64'(T1_STALL[c]));
      check("t1_mreq", 64'(mem_req), 64'(T1_MREQ[c]));
      if (c == 1) check("t1_addr", 64'(mem_addr), 64'(32'h0000_0100));
      if (c == 3) check("t1_rdata", 64'(if_rdata), 64'(32'h0000_0013));
      step();
    end

    // IF and ME together: ME store served first
    grants.delete();
    if_left = 1; s_if_addr = 32'h0000_0100;
    me_left = 1; s_me_addr = 32'h0000_1000; me_we = 1'b1; me_be = 4'hF; me_wdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 9; c++) begin
      drive_scripted();
      sample();
      if (c == 1) begin
        check("t2_we", 64'(mem_we), 64'(1'b1));
        check("t2_wdata", 64'(mem_wdata), 64'(32'hDEAD_BEEF));
        check("t2_addr", 64'(mem_addr), 64'(32'h0000_1000));
      end
      step();
    end
    check("t2_ngrants", 64'(grants.size()), 64'(2));
    for (int i = 0; i < 2; i++) check("t2_grant", 64'(grants[i]), 64'(G2[i]));

    // Five back-to-back ME reads while IF waits: starvation limit
    grants.delete();
    if_left = 1; s_if_addr = 32'h0000_0300;
    me_left = 5; s_me_addr = 32'h0000_2000; me_we = 1'b0; me_be = 4'hF; me_wdata = '0;
    for (int c = 0; c < 26; c++) begin
      drive_scripted();
      sample();
      step();
    end
    check("t3_ngrants", 64'(grants.size()), 64'(6));
    for (int i = 0; i < 6; i++) check("t3_grant", 64'(grants[i]), 64'(G3[i]));

    // Flush two cycles into a 4-cycle fetch
    force_lat = 4; fixed_data = 32'h1234_5678;
    for (int c = 0; c < 9; c++) begin
      if_req = (c <= 3); if_abort = (c == 3); if_addr = 32'h0000_0200; me_req = 1'b0;
      sample();
      check("t4_ack", 64'(if_ack), 64'(1'b0));
      check("t4_mreq", 64'(mem_req), 64'(T4_MREQ[c]));
      step();
    end

    // Reset in the middle of an ME transfer
    me_left = 1; s_me_addr = 32'h0000_3000; me_we = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive_scripted();
      sample();
      step();
    end
    pulse_reset();
    me_left = 0;
    for (int c = 0; c < 4; c++) begin
      drive_scripted();
      sample();
      check("t5_no_ack", 64'(me_ack), 64'(1'b0));
      step();
    end
    me_left = 1; s_me_addr = 32'h0000_3004; force_lat = 1; fixed_data = 32'h0BAD_F00D;
    for (int c = 0; c < 5; c++) begin
      drive_scripted();
      sample();
      check("t5_ack", 64'(me_ack), 64'(T1_ACK[c]));
      if (c == 3) check("t5_rdata", 64'(me_rdata), 64'(32'h0BAD_F00D));
      step();
    end

    // Random traffic with random memory latency and occasional resets
    force_lat = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        pulse_reset();
      end else begin
        drive_random();
        sample();
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
